// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single RAM or peripheral bus,
// with data priority bounded by an anti-starvation streak counter.
//   state   | meaning
//   IDLE    | arbitrate; streak counter updated here only
//   ACCESS  | target driven; RAM_LATENCY cycles for RAM, 1 for peripheral
//   RESPOND | last cycle of the transaction; ack/rdata registered out of it
module mem_arbiter #(
  parameter int RAM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic        ram_write_enable,
  input  logic [31:0] ram_data_out,
  output logic [31:0] per_addr,
  output logic [31:0] per_data_in,
  output logic        per_write_enable,
  input  logic [31:0] per_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX   = 4'(MAX_DATA_STREAK);
  localparam logic [3:0] RAM_CNT_INIT = 4'(RAM_LATENCY - 1);

  state_t      state_q, state_d;
  logic        owner_is_data_q, owner_is_data_d;
  logic        tgt_ram_q, tgt_ram_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] ram_address_q, ram_address_d;
  logic [31:0] ram_data_in_q, ram_data_in_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] per_addr_q, per_addr_d;
  logic [31:0] per_data_in_q, per_data_in_d;
  logic        per_we_q, per_we_d;
  logic        busy_q, busy_d;

  logic        gnt_fetch, gnt_data, gnt_ram, gnt_we;
  logic [31:0] gnt_addr;

  always_comb begin
    state_d         = state_q;
    owner_is_data_d = owner_is_data_q;
    tgt_ram_d       = tgt_ram_q;
    we_d            = we_q;
    cnt_d           = cnt_q;
    streak_d        = streak_q;
    cap_d           = cap_q;
    if_rdata_d      = if_rdata_q;
    d_rdata_d       = d_rdata_q;
    if_ack_d        = 1'b0;
    d_ack_d         = 1'b0;
    ram_address_d   = ram_address_q;
    ram_data_in_d   = ram_data_in_q;
    ram_we_d        = 1'b0;
    per_addr_d      = per_addr_q;
    per_data_in_d   = per_data_in_q;
    per_we_d        = 1'b0;
    gnt_fetch       = 1'b0;
    gnt_data        = 1'b0;
    gnt_ram         = 1'b0;
    gnt_we          = 1'b0;
    gnt_addr        = '0;

    case (state_q)
      IDLE: begin
        // Fetch wins a tie only once data has held the bus STREAK_MAX times in a row.
        gnt_fetch = if_req && (!d_req || (streak_q == STREAK_MAX));
        gnt_data  = d_req && !gnt_fetch;
        gnt_addr  = gnt_data ? d_addr : if_addr;
        gnt_ram   = (gnt_addr[31:29] == 3'b000);
        gnt_we    = gnt_data && d_we;

        if (!if_req || gnt_fetch) begin
          streak_d = '0;
        end else if (gnt_data && (streak_q != STREAK_MAX)) begin
          streak_d = streak_q + 4'd1;
        end

        if (gnt_fetch || gnt_data) begin
          state_d         = ACCESS;
          owner_is_data_d = gnt_data;
          tgt_ram_d       = gnt_ram;
          we_d            = gnt_we;
          if (gnt_ram) begin
            ram_address_d = gnt_addr;
            if (gnt_data) ram_data_in_d = d_wdata;
            ram_we_d      = gnt_we;
            cnt_d         = RAM_CNT_INIT;
          end else begin
            per_addr_d    = gnt_addr;
            if (gnt_data) per_data_in_d = d_wdata;
            per_we_d      = gnt_we;
            cnt_d         = 4'd0;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESPOND;
          if (!we_q) cap_d = tgt_ram_q ? ram_data_out : per_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESPOND: begin
        state_d = IDLE;
        if (owner_is_data_q) begin
          d_ack_d = 1'b1;
          if (!we_q) d_rdata_d = cap_q;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = cap_q;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_is_data_q <= 1'b0;
      tgt_ram_q       <= 1'b0;
      we_q            <= 1'b0;
      cnt_q           <= '0;
      streak_q        <= '0;
      cap_q           <= '0;
      if_rdata_q      <= '0;
      d_rdata_q       <= '0;
      if_ack_q        <= 1'b0;
      d_ack_q         <= 1'b0;
      ram_address_q   <= '0;
      ram_data_in_q   <= '0;
      ram_we_q        <= 1'b0;
      per_addr_q      <= '0;
      per_data_in_q   <= '0;
      per_we_q        <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_is_data_q <= owner_is_data_d;
      tgt_ram_q       <= tgt_ram_d;
      we_q            <= we_d;
      cnt_q           <= cnt_d;
      streak_q        <= streak_d;
      cap_q           <= cap_d;
      if_rdata_q      <= if_rdata_d;
      d_rdata_q       <= d_rdata_d;
      if_ack_q        <= if_ack_d;
      d_ack_q         <= d_ack_d;
      ram_address_q   <= ram_address_d;
      ram_data_in_q   <= ram_data_in_d;
      ram_we_q        <= ram_we_d;
      per_addr_q      <= per_addr_d;
      per_data_in_q   <= per_data_in_d;
      per_we_q        <= per_we_d;
      busy_q          <= busy_d;
    end
  end

  assign if_rdata         = if_rdata_q;
  assign if_ack           = if_ack_q;
  assign d_rdata          = d_rdata_q;
  assign d_ack            = d_ack_q;
  assign ram_address      = ram_address_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_write_enable = ram_we_q;
  assign per_addr         = per_addr_q;
  assign per_data_in      = per_data_in_q;
  assign per_write_enable = per_we_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timestamp reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
  localparam int RAM_LAT = 2;
  localparam int MAXS    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_ack, d_ack;
  logic [31:0] ram_address, ram_data_in, ram_data_out;
  logic        ram_write_enable;
  logic [31:0] per_addr, per_data_in, per_rdata;
  logic        per_write_enable, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.RAM_LATENCY(RAM_LAT), .MAX_DATA_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out),
    .per_addr(per_addr), .per_data_in(per_data_in),
    .per_write_enable(per_write_enable), .per_rdata(per_rdata), .busy(busy)
  );

  function automatic logic [31:0] fill_val(input int i);
    if (i == 4)  return 32'hDEADBEEF;
    if (i == 18) return 32'h00500093;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] per_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  // RAM (async read, word-indexed) and peripheral environment
  logic [31:0] ram_mem [0:63];
  assign ram_data_out = ram_mem[ram_address[7:2]];
  assign per_rdata    = per_fn(per_addr);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= fill_val(i);
    end else if (ram_write_enable) begin
      ram_mem[ram_address[7:2]] <= ram_data_in;
    end
  end

  // Reference model: each grant at edge e schedules its strobes for the cycle
  // after e, and its ack/rdata for the cycle after e+L+1.
  logic [31:0] shadow [0:63];
  int          edge_n = 0;
  bit          m_ok = 1'b0, m_active = 1'b0, m_owner_d, m_we, m_gf, m_gd, m_tr;
  int          m_end, m_streak, m_lat;
  logic [31:0] m_val, m_a;
  logic [31:0] exp_if_rdata, exp_d_rdata, exp_ram_address, exp_ram_data_in;
  logic [31:0] exp_per_addr, exp_per_data_in;
  logic        exp_if_ack, exp_d_ack, exp_ram_we, exp_per_we, exp_busy;

  always @(posedge clk) begin
    edge_n++;
    exp_ram_we = 1'b0;
    exp_per_we = 1'b0;
    exp_if_ack = 1'b0;
    exp_d_ack  = 1'b0;
    if (rst) begin
      m_ok = 1'b1; m_active = 1'b0; m_streak = 0;
      exp_if_rdata = '0; exp_d_rdata = '0; exp_ram_address = '0;
      exp_ram_data_in = '0; exp_per_addr = '0; exp_per_data_in = '0;
      for (int i = 0; i < 64; i++) shadow[i] = fill_val(i);
    end else if (!m_active) begin
      m_gf = if_req && (!d_req || m_streak == MAXS);
      m_gd = d_req && !m_gf;
      if (!if_req || m_gf) m_streak = 0;
      else if (m_gd && m_streak < MAXS) m_streak++;
      if (m_gf || m_gd) begin
        m_a       = m_gd ? d_addr : if_addr;
        m_tr      = (m_a[31:29] == 3'b000);
        m_lat     = m_tr ? RAM_LAT : 1;
        m_active  = 1'b1;
        m_end     = edge_n + m_lat + 1;
        m_owner_d = m_gd;
        m_we      = m_gd && d_we;
        if (m_tr) begin
          exp_ram_address = m_a;
          if (m_gd) exp_ram_data_in = d_wdata;
          exp_ram_we = m_we;
          if (m_we) shadow[m_a[7:2]] = d_wdata;
          m_val = shadow[m_a[7:2]];
        end else begin
          exp_per_addr = m_a;
          if (m_gd) exp_per_data_in = d_wdata;
          exp_per_we = m_we;
          m_val = per_fn(m_a);
        end
      end
    end else if (edge_n == m_end) begin
      m_active = 1'b0;
      if (m_owner_d) begin
        exp_d_ack = 1'b1;
        if (!m_we) exp_d_rdata = m_val;
      end else begin
        exp_if_ack   = 1'b1;
        exp_if_rdata = m_val;
      end
    end
    exp_busy = m_active;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic compare_all();
    chk("busy",        32'(busy),             32'(exp_busy));
    chk("if_ack",      32'(if_ack),           32'(exp_if_ack));
    chk("d_ack",       32'(d_ack),            32'(exp_d_ack));
    chk("if_rdata",    if_rdata,              exp_if_rdata);
    chk("d_rdata",     d_rdata,               exp_d_rdata);
    chk("ram_we",      32'(ram_write_enable), 32'(exp_ram_we));
    chk("per_we",      32'(per_write_enable), 32'(exp_per_we));
    chk("ram_address", ram_address,           exp_ram_address);
    chk("ram_data_in", ram_data_in,           exp_ram_data_in);
    chk("per_addr",    per_addr,              exp_per_addr);
    chk("per_data_in", per_data_in,           exp_per_data_in);
  endtask

  // One clock: compare mid-cycle, then return 1 time unit after the next edge.
  task automatic step();
    @(negedge clk);
    if (m_ok) compare_all();
    @(posedge clk);
    #1;
  endtask

  int          ram_we_cnt, per_we_cnt, other_ack;
  logic [31:0] acc_ram_addr, seen_per_addr, seen_per_wd;

  task automatic run_one(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd);
    lat = -1; rd = '0; ram_we_cnt = 0; per_we_cnt = 0; other_ack = 0;
    acc_ram_addr = '0; seen_per_addr = '0; seen_per_wd = '0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n == 1) acc_ram_addr = ram_address;
      if (ram_write_enable) ram_we_cnt++;
      if (per_write_enable) begin
        per_we_cnt++; seen_per_addr = per_addr; seen_per_wd = per_data_in;
      end
      if (is_d ? if_ack : d_ack) other_ack++;
      if (is_d ? d_ack : if_ack) begin
        lat = n; rd = is_d ? d_rdata : if_rdata;
        break;
      end
    end
    d_req = 1'b0; d_we = 1'b0; if_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return {3'b000, 29'($urandom)};
    return {3'($urandom_range(1, 7)), 29'($urandom)};
  endfunction

  int          lat, nack, dbl, acks;
  logic [31:0] rd;
  logic [9:0]  order;
  bit          prev, cur;

  initial begin
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("idle_busy",   32'(busy), 0);
    chk("idle_acks",   32'(if_ack | d_ack), 0);
    chk("idle_we",     32'(ram_write_enable | per_write_enable), 0);
    chk("idle_ramadr", ram_address, 0);
    chk("idle_rdata",  if_rdata | d_rdata, 0);

    run_one(1'b1, 1'b0, 32'h0000_0010, 32'h0, lat, rd);
    chk("ramld_lat",    lat - 1, 3);
    chk("ramld_rdata",  rd, 32'hDEADBEEF);
    chk("ramld_addr",   acc_ram_addr, 32'h10);
    chk("ramld_if_ack", other_ack, 0);
    step(); step();

    run_one(1'b1, 1'b1, 32'h2000_0000, 32'd5, lat, rd);
    chk("perst_lat",   lat - 1, 2);
    chk("perst_wecnt", per_we_cnt, 1);
    chk("perst_addr",  seen_per_addr, 32'h2000_0000);
    chk("perst_wdata", seen_per_wd, 32'd5);
    chk("perst_ramwe", ram_we_cnt, 0);
    step(); step();

    run_one(1'b0, 1'b0, 32'h0000_0048, 32'h0, lat, rd);
    chk("fetch_lat",   lat - 1, 3);
    chk("fetch_rdata", rd, 32'h00500093);
    chk("fetch_ramwe", ram_we_cnt, 0);
    step(); step();

    d_we = 1'b0; d_addr = 32'h10; if_addr = 32'h48;
    if_req = 1'b1; d_req = 1'b1;
    order = '0; nack = 0; dbl = 0; prev = 1'b0;
    for (int n = 0; n < 400 && nack < 10; n++) begin
      step();
      cur = if_ack | d_ack;
      if (cur && prev) dbl++;
      if (d_ack) begin
        order = {order[8:0], 1'b1}; nack++;
      end else if (if_ack) begin
        order = {order[8:0], 1'b0}; nack++;
      end
      prev = cur;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("sim_order", 32'(order), 32'(10'b1111011110));
    chk("sim_count", nack, 10);
    chk("sim_pulse", dbl, 0);
    step(); step();

    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
    step();
    chk("rstmid_we_first", 32'(ram_write_enable), 1);
    rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
    step();
    chk("rstmid_we",   32'(ram_write_enable), 0);
    chk("rstmid_busy", 32'(busy), 0);
    rst = 1'b0;
    acks = 0;
    repeat (8) begin
      step();
      if (d_ack) acks++;
    end
    chk("rstmid_noack", acks, 0);

    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        continue;
      end
      if (if_req && if_ack) if_req = 1'b0;
      if (d_req && d_ack) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr(); d_wdata = $urandom;
      end
    end
    if_req = 1'b0; d_req = 1'b0; rst = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port RAM/peripheral bus between two requesters: instruction fetch (read-only) and the memory stage (load/store).
- Sits between the pipeline and the RAM / peripheral_manager. Decodes the address map: addr[31:29]==3'b000 selects RAM; any other value selects the peripheral bus.
- Data port has priority, except that an anti-starvation streak counter forces a fetch grant after a bounded number of consecutive data grants.
- One outstanding transaction at a time; every handshake is req/ack.

Parameters:
- RAM_LATENCY, 2: cycles in ACCESS for a RAM target, range 1..15.
- MAX_DATA_STREAK, 4: consecutive data grants allowed while if_req is pending before fetch is forced, range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch address
- if_rdata  out  32  fetch read data; valid while if_ack=1, held afterwards
- if_ack  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data; valid while d_ack=1, held afterwards
- d_ack  out  1  one-cycle completion pulse for data
- ram_address  out  32  RAM address
- ram_data_in  out  32  RAM write data
- ram_write_enable  out  1  RAM write strobe
- ram_data_out  in  32  RAM read data
- per_addr  out  32  peripheral address
- per_data_in  out  32  peripheral write data
- per_write_enable  out  1  peripheral write strobe
- per_rdata  in  32  peripheral read data, combinationally valid in the same cycle
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, streak counter 0, every output 0.
- Reset mid-transaction: the transaction is aborted. No ack is issued, and the write strobes read 0 from the reset edge on.
- States: IDLE, ACCESS, RESPOND.
- IDLE, arbitration at each rising edge:
  - Only one req high: that port is granted.
  - Both high: data is granted, unless streak==MAX_DATA_STREAK, in which case fetch is granted.
- On grant, the arbiter latches owner, target, addr, we and wdata, then moves to ACCESS. we is forced to 0 for fetch.
- Streak counter:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, or whenever if_req=0 in IDLE.
  - Saturates at MAX_DATA_STREAK.
- ACCESS, RAM target:
  - Lasts RAM_LATENCY cycles (down-counter).
  - ram_address and ram_data_in are registered and held stable for the whole of ACCESS.
  - ram_write_enable is high in the first ACCESS cycle only.
  - On the last ACCESS cycle's edge, ram_data_out is captured for loads.
- ACCESS, peripheral target:
  - Always exactly 1 cycle.
  - per_addr and per_data_in are driven; per_write_enable is high for that cycle if we=1.
  - per_rdata is captured at the end of that cycle for loads.
- RESPOND:
  - The owner's ack is high for exactly one cycle, and the captured data appears on the owner's rdata in the same cycle. The state then returns to IDLE.
  - A store ack leaves d_rdata unchanged.
- Latency: the request is sampled at edge k. The ack is visible after edge k+L+1, where L = RAM_LATENCY (RAM) or 1 (peripheral).
  - Minimum transaction: L+2 cycles, since the IDLE sample cycle also counts.
- The non-owner's req is ignored until the next IDLE. Its ack and rdata stay unchanged.
- Idle outputs:
  - ram_write_enable and per_write_enable are 0 outside the defined strobe cycle.
  - Address and data outputs hold their last values.
- A requester that drops req before ack violates protocol. The transaction still completes and acks.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then no requests → all outputs 0, busy=0, no strobes.
- RAM load:
  - Setup: RAM_LATENCY=2, ram_data_out model returns 32'hDEADBEEF.
  - Stimulus: d_req=1, d_we=0, d_addr=32'h0000_0010 sampled at edge k.
  - Required: ram_address=32'h10 during ACCESS; d_ack=1 with d_rdata=32'hDEADBEEF after edge k+3; if_ack stays 0.
- Peripheral store: d_we=1, d_addr=32'h2000_0000, d_wdata=5 → per_write_enable high exactly 1 cycle with per_addr=32'h2000_0000 and per_data_in=5; ram_write_enable stays 0; d_ack after edge k+2.
- Simultaneous requests: if_req and d_req held high continuously, MAX_DATA_STREAK=4 → grant order D,D,D,D,F,D,D,D,D,F; each ack pulse is one cycle.
- Fetch only: if_req=1, if_addr=32'h48, ram_data_out returns 32'h00500093 → if_ack with if_rdata=32'h00500093; ram_write_enable never asserted.
- Reset mid-ACCESS of a RAM store: rst asserted in the first ACCESS cycle → no d_ack; ram_write_enable=0 after the reset edge; state IDLE; streak 0.
